// File: rtl/fx_pkg.sv
// Shared types and sizing for the fixed-point operand fetch stage.
package fx_pkg;

  localparam int unsigned REG_SIZE     = 64;
  localparam int unsigned GPR_ADDR_W   = 6;
  localparam int unsigned NUM_RD_PORTS = 3;
  localparam int unsigned NUM_WR_PORTS = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD1   = 3'd1,
    RD2   = 3'd2,
    CAP   = 3'd3,
    VALID = 3'd4
  } fx_state_e;

endpackage

// File: rtl/fx_bypass_match.sv
// Compares one source GPR address against every snooped write port and returns
// the value of the highest-numbered matching port.
module fx_bypass_match
  import fx_pkg::*;
#(
  parameter int unsigned DATA_W = REG_SIZE,
  parameter int unsigned ADDR_W = GPR_ADDR_W
) (
  input  logic [ADDR_W-1:0]                   srcAddr_i,
  input  logic [NUM_WR_PORTS-1:0]             wrEn_i,
  input  logic [NUM_WR_PORTS-1:0][ADDR_W-1:0] wrAddr_i,
  input  logic [NUM_WR_PORTS-1:0][DATA_W-1:0] wrVal_i,
  output logic                                hit_o,
  output logic [DATA_W-1:0]                   val_o
);

  // Ascending scan so a later (higher) port overrides an earlier match.
  always_comb begin
    hit_o = 1'b0;
    val_o = '0;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      if (wrEn_i[p] && (wrAddr_i[p] == srcAddr_i)) begin
        hit_o = 1'b1;
        val_o = wrVal_i[p];
      end
    end
  end

endmodule

// File: rtl/fx_operand_fetch.sv
// Operand fetch: latches an issued instruction, reads up to three GPRs and hands
// operands plus payload to execute. Define FX_OPFETCH_BYPASS_EN to forward snooped writes.
module fx_operand_fetch
  import fx_pkg::*;
#(
  parameter int unsigned regSize           = REG_SIZE,
  parameter int unsigned numGPRAddressBits = GPR_ADDR_W,
  parameter int unsigned payloadWidth      = 32
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic                         inValid_i,
  output logic                         inReady_o,
  input  logic [2:0]                   inSrcEn_i,
  input  logic [numGPRAddressBits-1:0] inSrc1Addr_i,
  input  logic [numGPRAddressBits-1:0] inSrc2Addr_i,
  input  logic [numGPRAddressBits-1:0] inSrc3Addr_i,
  input  logic [payloadWidth-1:0]      inPayload_i,
  output logic                         gprRead1En_o,
  output logic                         gprRead2En_o,
  output logic                         gprRead3En_o,
  output logic [numGPRAddressBits-1:0] gprReadAddr1_o,
  output logic [numGPRAddressBits-1:0] gprReadAddr2_o,
  output logic [numGPRAddressBits-1:0] gprReadAddr3_o,
  input  logic [regSize-1:0]           gprRead1_i,
  input  logic [regSize-1:0]           gprRead2_i,
  input  logic [regSize-1:0]           gprRead3_i,
  input  logic                         gprWrite1En_i,
  input  logic                         gprWrite2En_i,
  input  logic                         gprWrite3En_i,
  input  logic                         gprWrite4En_i,
  input  logic [numGPRAddressBits-1:0] gprWriteAddr1_i,
  input  logic [numGPRAddressBits-1:0] gprWriteAddr2_i,
  input  logic [numGPRAddressBits-1:0] gprWriteAddr3_i,
  input  logic [numGPRAddressBits-1:0] gprWriteAddr4_i,
  input  logic [regSize-1:0]           gprWrite1Val_i,
  input  logic [regSize-1:0]           gprWrite2Val_i,
  input  logic [regSize-1:0]           gprWrite3Val_i,
  input  logic [regSize-1:0]           gprWrite4Val_i,
  output logic                         outValid_o,
  input  logic                         outReady_i,
  output logic [regSize-1:0]           outOp1_o,
  output logic [regSize-1:0]           outOp2_o,
  output logic [regSize-1:0]           outOp3_o,
  output logic [payloadWidth-1:0]      outPayload_o
);

  fx_state_e                                       state_q;
  logic [NUM_RD_PORTS-1:0]                         srcEn_q;
  logic [NUM_RD_PORTS-1:0][numGPRAddressBits-1:0]  srcAddr_q;
  logic [payloadWidth-1:0]                         payload_q;
  logic [NUM_RD_PORTS-1:0][regSize-1:0]            op_q;
  logic [NUM_RD_PORTS-1:0]                         fwdHit_q;
  logic [NUM_RD_PORTS-1:0][regSize-1:0]            fwdVal_q;

  logic [NUM_RD_PORTS-1:0][regSize-1:0]            rdData;
  logic [NUM_RD_PORTS-1:0]                         hit;
  logic [NUM_RD_PORTS-1:0][regSize-1:0]            hitVal;
  logic [NUM_RD_PORTS-1:0][regSize-1:0]            capVal;

  assign rdData = {gprRead3_i, gprRead2_i, gprRead1_i};

`ifdef FX_OPFETCH_BYPASS_EN
  logic [NUM_WR_PORTS-1:0]                         wrEn;
  logic [NUM_WR_PORTS-1:0][numGPRAddressBits-1:0]  wrAddr;
  logic [NUM_WR_PORTS-1:0][regSize-1:0]            wrVal;
  logic [NUM_RD_PORTS-1:0]                         matchHit;

  assign wrEn   = {gprWrite4En_i, gprWrite3En_i, gprWrite2En_i, gprWrite1En_i};
  assign wrAddr = {gprWriteAddr4_i, gprWriteAddr3_i, gprWriteAddr2_i, gprWriteAddr1_i};
  assign wrVal  = {gprWrite4Val_i, gprWrite3Val_i, gprWrite2Val_i, gprWrite1Val_i};

  for (genvar n = 0; n < NUM_RD_PORTS; n++) begin : g_match
    fx_bypass_match #(
      .DATA_W (regSize),
      .ADDR_W (numGPRAddressBits)
    ) u_match (
      .srcAddr_i (srcAddr_q[n]),
      .wrEn_i    (wrEn),
      .wrAddr_i  (wrAddr),
      .wrVal_i   (wrVal),
      .hit_o     (matchHit[n]),
      .val_o     (hitVal[n])
    );
  end

  // Disabled sources never forward, so their operand stays zero.
  assign hit = matchHit & srcEn_q;
`else
  logic unused_snoop;

  assign hit          = '0;
  assign hitVal       = '0;
  assign unused_snoop = ^{gprWrite1En_i, gprWrite2En_i, gprWrite3En_i, gprWrite4En_i,
                          gprWriteAddr1_i, gprWriteAddr2_i, gprWriteAddr3_i, gprWriteAddr4_i,
                          gprWrite1Val_i, gprWrite2Val_i, gprWrite3Val_i, gprWrite4Val_i};
`endif

  // A write seen on the capture edge is newer than anything remembered from RD1/RD2.
  always_comb begin
    capVal = '0;
    for (int n = 0; n < NUM_RD_PORTS; n++) begin
      if (!srcEn_q[n])       capVal[n] = '0;
      else if (hit[n])       capVal[n] = hitVal[n];
      else if (fwdHit_q[n])  capVal[n] = fwdVal_q[n];
      else                   capVal[n] = rdData[n];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      srcEn_q   <= '0;
      srcAddr_q <= '0;
      payload_q <= '0;
      op_q      <= '0;
      fwdHit_q  <= '0;
      fwdVal_q  <= '0;
    end else if (flush_i) begin
      state_q  <= IDLE;
      fwdHit_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (inValid_i) begin
            srcEn_q   <= inSrcEn_i;
            srcAddr_q <= {inSrc3Addr_i, inSrc2Addr_i, inSrc1Addr_i};
            payload_q <= inPayload_i;
            fwdHit_q  <= '0;
            state_q   <= RD1;
          end
        end
        RD1, RD2: begin
          for (int n = 0; n < NUM_RD_PORTS; n++) begin
            if (hit[n]) begin
              fwdHit_q[n] <= 1'b1;
              fwdVal_q[n] <= hitVal[n];
            end
          end
          state_q <= (state_q == RD1) ? RD2 : CAP;
        end
        CAP: begin
          op_q    <= capVal;
          state_q <= VALID;
        end
        VALID: begin
          for (int n = 0; n < NUM_RD_PORTS; n++) begin
            if (hit[n]) op_q[n] <= hitVal[n];
          end
          if (outReady_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inReady_o      = (state_q == IDLE);
  assign outValid_o     = (state_q == VALID);
  assign gprRead1En_o   = (state_q == RD1) & srcEn_q[0];
  assign gprRead2En_o   = (state_q == RD1) & srcEn_q[1];
  assign gprRead3En_o   = (state_q == RD1) & srcEn_q[2];
  assign gprReadAddr1_o = srcAddr_q[0];
  assign gprReadAddr2_o = srcAddr_q[1];
  assign gprReadAddr3_o = srcAddr_q[2];
  assign outOp1_o       = op_q[0];
  assign outOp2_o       = op_q[1];
  assign outOp3_o       = op_q[2];
  assign outPayload_o   = payload_q;

endmodule

// File: tb/tb_fx_operand_fetch.sv
// Scoreboard bench for fx_operand_fetch with a two-cycle-latency regfile model.
module tb_fx_operand_fetch;

  localparam int RS = 64;
  localparam int AW = 6;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               flush_i, inValid_i, inReady_o, outValid_o, outReady_i;
  logic [2:0]         inSrcEn_i;
  logic [2:0][AW-1:0] inAddr;
  logic [PW-1:0]      inPayload_i, outPayload_o;
  logic [2:0]         rdEn;
  logic [2:0][AW-1:0] rdAddr;
  logic [2:0][RS-1:0] rdS1, rdS2;
  logic [3:0]         wr_en;
  logic [3:0][AW-1:0] wr_addr;
  logic [3:0][RS-1:0] wr_val;
  logic [2:0][RS-1:0] outOp;

  typedef struct packed {
    logic [2:0][RS-1:0] op;
    logic [PW-1:0]      pl;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [2:0][3:0]         pl_en;
  logic [2:0][3:0][AW-1:0] pl_addr;
  logic [2:0][3:0][RS-1:0] pl_val;

  fx_operand_fetch dut (
    .clock_i(clk), .reset_i(rst), .flush_i(flush_i),
    .inValid_i(inValid_i), .inReady_o(inReady_o), .inSrcEn_i(inSrcEn_i),
    .inSrc1Addr_i(inAddr[0]), .inSrc2Addr_i(inAddr[1]), .inSrc3Addr_i(inAddr[2]),
    .inPayload_i(inPayload_i),
    .gprRead1En_o(rdEn[0]), .gprRead2En_o(rdEn[1]), .gprRead3En_o(rdEn[2]),
    .gprReadAddr1_o(rdAddr[0]), .gprReadAddr2_o(rdAddr[1]), .gprReadAddr3_o(rdAddr[2]),
    .gprRead1_i(rdS2[0]), .gprRead2_i(rdS2[1]), .gprRead3_i(rdS2[2]),
    .gprWrite1En_i(wr_en[0]), .gprWrite2En_i(wr_en[1]),
    .gprWrite3En_i(wr_en[2]), .gprWrite4En_i(wr_en[3]),
    .gprWriteAddr1_i(wr_addr[0]), .gprWriteAddr2_i(wr_addr[1]),
    .gprWriteAddr3_i(wr_addr[2]), .gprWriteAddr4_i(wr_addr[3]),
    .gprWrite1Val_i(wr_val[0]), .gprWrite2Val_i(wr_val[1]),
    .gprWrite3Val_i(wr_val[2]), .gprWrite4Val_i(wr_val[3]),
    .outValid_o(outValid_o), .outReady_i(outReady_i),
    .outOp1_o(outOp[0]), .outOp2_o(outOp[1]), .outOp3_o(outOp[2]),
    .outPayload_o(outPayload_o)
  );

  // Regfile: address sampled on the enable edge, data presented two cycles later.
  logic [RS-1:0] mem [64];
  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      rdS1[n] <= rdEn[n] ? mem[rdAddr[n]] : 64'hBAD0_BAD0_BAD0_BAD0;
      rdS2[n] <= rdS1[n];
    end
    for (int p = 0; p < 4; p++)
      if (wr_en[p]) mem[wr_addr[p]] <= wr_val[p];
  end

  task automatic chk(input string name, input logic [RS-1:0] act, input logic [RS-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic clear_plan();
    pl_en = '0; pl_addr = '0; pl_val = '0;
  endtask

  task automatic drive_writes(input int s);
    for (int p = 0; p < 4; p++) begin
      wr_en[p]   = pl_en[s][p];
      wr_addr[p] = pl_addr[s][p];
      wr_val[p]  = pl_val[s][p];
    end
  endtask

  // Issue one instruction with the current write plan; writes land on the RD1, RD2, CAP edges.
  task automatic issue(input logic [2:0][AW-1:0] a, input logic [2:0] en,
                       input logic [PW-1:0] pl, input int rdly);
    exp_t e;
    logic [RS-1:0] v;
    int guard = 0;
    while (inReady_o !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    if (inReady_o !== 1'b1) begin
      chk("issue_ready_timeout", {63'd0, inReady_o}, 64'd1);
      return;
    end
    for (int n = 0; n < 3; n++) begin
      v = mem[a[n]];
`ifdef FX_OPFETCH_BYPASS_EN
      for (int s = 0; s < 3; s++)
        for (int p = 0; p < 4; p++)
          if (pl_en[s][p] && pl_addr[s][p] == a[n]) v = pl_val[s][p];
`endif
      e.op[n] = en[n] ? v : '0;
    end
    e.pl = pl;
    sb_q.push_back(e);
    inValid_i = 1'b1; inAddr = a; inSrcEn_i = en; inPayload_i = pl; outReady_i = 1'b0;
    @(negedge clk);
    inValid_i = 1'b0;
    chk("rd1_enables", {61'd0, rdEn}, {61'd0, en});
    for (int n = 0; n < 3; n++) chk("rd1_addr", {58'd0, rdAddr[n]}, {58'd0, a[n]});
    chk("rd1_valid", {63'd0, outValid_o}, 64'd0);
    drive_writes(0);
    @(negedge clk);
    chk("rd2_enables", {61'd0, rdEn}, 64'd0);
    drive_writes(1);
    @(negedge clk);
    chk("cap_valid", {63'd0, outValid_o}, 64'd0);
    drive_writes(2);
    @(negedge clk);
    wr_en = '0;
    chk("latency_valid", {63'd0, outValid_o}, 64'd1);
    for (int i = 0; i < rdly; i++) begin
      chk("hold_in_ready", {63'd0, inReady_o}, 64'd0);
      @(negedge clk);
      chk("hold_valid", {63'd0, outValid_o}, 64'd1);
    end
    outReady_i = 1'b1;
    @(negedge clk);
    outReady_i = 1'b0;
    chk("ready_after_take", {63'd0, inReady_o}, 64'd1);
  endtask

  // Monitor: samples one time unit before each rising edge.
  initial begin
    exp_t e;
    logic pv;
    logic [2:0][RS-1:0] pop;
    logic [PW-1:0] ppl;
    pv = 1'b0; pop = '0; ppl = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst || !outValid_o) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          for (int n = 0; n < 3; n++) chk("stable_op", outOp[n], pop[n]);
          chk("stable_payload", {32'd0, outPayload_o}, {32'd0, ppl});
        end
        if (outReady_i) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            chk("op1", outOp[0], e.op[0]);
            chk("op2", outOp[1], e.op[1]);
            chk("op3", outOp[2], e.op[2]);
            chk("payload", {32'd0, outPayload_o}, {32'd0, e.pl});
          end
          pv = 1'b0;
        end else begin
          pv = 1'b1; pop = outOp; ppl = outPayload_o;
        end
      end
    end
  end

  initial begin
    logic [2:0][AW-1:0] a;
    flush_i = 0; inValid_i = 0; inSrcEn_i = 0; inAddr = '0; inPayload_i = 0; outReady_i = 0;
    wr_en = '0; wr_addr = '0; wr_val = '0;
    clear_plan();
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", {63'd0, outValid_o}, 64'd0);
    chk("rst_enables", {61'd0, rdEn}, 64'd0);
    chk("rst_op1", outOp[0], 64'd0);
    chk("rst_payload", {32'd0, outPayload_o}, 64'd0);
    chk("rst_addr1", {58'd0, rdAddr[0]}, 64'd0);
    // Preload the regfile through the write ports while the DUT is held in reset.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        wr_en[p] = 1'b1;
        wr_addr[p] = AW'(4 * i + p);
        wr_val[p] = {$urandom, $urandom};
        if (4 * i + p == 5) wr_val[p] = 64'h11;
        if (4 * i + p == 7) wr_val[p] = 64'h22;
      end
    end
    @(negedge clk);
    wr_en = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {63'd0, inReady_o}, 64'd1);
    chk("post_rst_enables", {61'd0, rdEn}, 64'd0);
    @(negedge clk);

    // Basic read: src1=5, src2=7, src3 disabled.
    a = '0; a[0] = 6'd5; a[1] = 6'd7; a[2] = 6'd9;
    issue(a, 3'b011, 32'hA5A5_0001, 0);
    // Back-pressure for five cycles.
    issue(a, 3'b011, 32'hA5A5_0002, 5);

    // Writes to GPR5 on RD2 (port 2) and CAP (port 1).
    clear_plan();
    pl_en[1][1] = 1'b1; pl_addr[1][1] = 6'd5; pl_val[1][1] = 64'h99;
    pl_en[2][0] = 1'b1; pl_addr[2][0] = 6'd5; pl_val[2][0] = 64'hAA;
    a = '0; a[0] = 6'd5;
    issue(a, 3'b001, 32'hB0B0_0003, 0);
    // Same edge, ports 1 and 4 to the same register.
    clear_plan();
    pl_en[0][0] = 1'b1; pl_addr[0][0] = 6'd5; pl_val[0][0] = 64'hB1;
    pl_en[0][3] = 1'b1; pl_addr[0][3] = 6'd5; pl_val[0][3] = 64'hB4;
    issue(a, 3'b001, 32'hB0B0_0004, 1);
    clear_plan();

    // Flush in RD2 discards the instruction.
    inValid_i = 1'b1; inSrcEn_i = 3'b111; inPayload_i = 32'hF1F1_F1F1;
    @(negedge clk); inValid_i = 1'b0;
    @(negedge clk); flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0;
    chk("flush_idle", {63'd0, inReady_o}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("flush_no_valid", {63'd0, outValid_o}, 64'd0);
      @(negedge clk);
    end
    // Flush together with inValid in IDLE is not an accept.
    flush_i = 1'b1; inValid_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; inValid_i = 1'b0;
    chk("flush_no_accept", {63'd0, inReady_o}, 64'd1);
    chk("flush_no_enable", {61'd0, rdEn}, 64'd0);

    // Reset asserted mid-cycle while in CAP.
    inValid_i = 1'b1; inSrcEn_i = 3'b111; inAddr = '0; inPayload_i = 32'hC0DE_0000;
    @(negedge clk); inValid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", {63'd0, outValid_o}, 64'd0);
    chk("midrst_op1", outOp[0], 64'd0);
    chk("midrst_op2", outOp[1], 64'd0);
    chk("midrst_payload", {32'd0, outPayload_o}, 64'd0);
    chk("midrst_addr2", {58'd0, rdAddr[1]}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", {63'd0, inReady_o}, 64'd1);
    chk("midrst_enables", {61'd0, rdEn}, 64'd0);
    chk("midrst_no_valid", {63'd0, outValid_o}, 64'd0);
    @(negedge clk);

    // Randomized traffic over a small address window to provoke write/read collisions.
    for (int t = 0; t < 40; t++) begin
      clear_plan();
      for (int s = 0; s < 3; s++)
        for (int p = 0; p < 4; p++)
          if ($urandom_range(0, 9) < 3) begin
            pl_en[s][p] = 1'b1;
            pl_addr[s][p] = AW'($urandom_range(0, 7));
            pl_val[s][p] = {$urandom, $urandom};
          end
      for (int n = 0; n < 3; n++) a[n] = AW'($urandom_range(0, 7));
      issue(a, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3));
    end
    clear_plan();
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
